wb_regfile: RTL
===============

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-writeback counter.
REQ-002 clk  input  1  system clock; all state updates on the posedge (MEM/WB register updates on the negedge).
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 power  input  1  pipeline enable; low holds all state and blocks writes.
REQ-005 control  input  8  MEM/WB control byte: bit0 RegWrite, bit1 MemtoReg, bits7:2 ignored.
REQ-006 read_data  input  32  MEM/WB load data.
REQ-007 alu_result  input  32  MEM/WB ALU result.
REQ-008 write_reg  input  5  MEM/WB destination register index.
REQ-009 rs_addr, rt_addr  input  5 each  ID-stage read-port addresses.
REQ-010 rs_data, rt_data  output  32 each  read-port data, combinational.
REQ-011 wb_data  output  32  selected writeback value, combinational.
REQ-012 wb_en  output  1  writeback commit strobe for this cycle, combinational.
REQ-013 retired  output  CNT_W  count of committed writebacks, registered.

Function
REQ-014 wb_data SHALL equal read_data when control[1]=1, else alu_result.
REQ-015 wb_en SHALL equal control[0] AND power AND NOT reset AND (write_reg != 0).
REQ-016 Storage SHALL be 32 x 32-bit registers; r0 SHALL read 0 at all times and never be written.
REQ-017 At posedge clk with wb_en=1, register[write_reg] SHALL take wb_data; no other register changes.
REQ-018 rs_data SHALL be 0 if rs_addr=0; else wb_data if wb_en=1 and rs_addr=write_reg (write-through bypass); else register[rs_addr]. Same rule for rt_data/rt_addr.
REQ-019 Bypass SHALL apply to both ports simultaneously when both addresses match write_reg.
REQ-020 retired SHALL increment by 1 at each posedge with wb_en=1, wrapping from 2^CNT_W-1 to 0.
REQ-021 Writes to index 0 with RegWrite=1 SHALL not commit and SHALL not increment retired.
REQ-022 power=0 SHALL hold registers and retired unchanged; reads (stored values, no bypass since wb_en=0) remain valid.
REQ-023 control/data inputs SHALL be treated as stable across the posedge (sampled half a cycle after the MEM/WB negedge update); no internal input registering.
REQ-024 Latency: committed value visible on read ports in the same cycle via bypass, and from storage from the following cycle onward.

Reset
REQ-025 At posedge clk with reset=1, all 32 registers SHALL become 0 and retired SHALL become 0, regardless of power or control.
REQ-026 reset SHALL take priority over a simultaneous write; the write SHALL be lost, not deferred.
REQ-027 During reset, wb_en SHALL be 0, so rs_data/rt_data SHALL reflect stored (cleared after the edge) values only.
REQ-028 First write SHALL be accepted on the first posedge with reset=0.

Verification
REQ-029 Reset, then control=01h, alu_result=0000_00AAh, write_reg=5, power=1 -> same cycle rs_addr=5 reads 0000_00AAh (bypass); after posedge rs reads 0000_00AAh from storage, retired=1.
REQ-030 control=03h, read_data=DEAD_BEEFh, alu_result=1234h, write_reg=31 -> wb_data=DEAD_BEEFh, reg31=DEAD_BEEFh after posedge; rs_addr=rt_addr=31 both return DEAD_BEEFh.
REQ-031 control=01h, write_reg=0, alu_result=FFFF_FFFFh -> wb_en=0, rs_addr=0 reads 0, retired unchanged.
REQ-032 power=0, control=01h, write_reg=7, alu_result=55h for 3 cycles -> reg7 unchanged, retired unchanged; restore power=1 -> reg7=55h after one posedge, retired +1.
REQ-033 Load reg3=77h, then assert reset with concurrent write to reg4=99h -> after posedge reg3=0, reg4=0, retired=0.
REQ-034 CNT_W=4, 17 consecutive valid writes from reset -> retired reads 1 (wrap at 16).

Source files
------------

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: MEM/WB writeback and ID read-port signals of the register file
interface wb_regfile_if #(parameter int CNT_W = 32);
  logic power;
  logic [7:0] control;
  logic [31:0] read_data;
  logic [31:0] alu_result;
  logic [4:0] write_reg;
  logic [4:0] rs_addr;
  logic [4:0] rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] wb_data;
  logic wb_en;
  logic [CNT_W-1:0] retired;
  modport master (
    output power, control, read_data, alu_result, write_reg, rs_addr, rt_addr,
    input rs_data, rt_data, wb_data, wb_en, retired
  );
  modport slave (
    input power, control, read_data, alu_result, write_reg, rs_addr, rt_addr,
    output rs_data, rt_data, wb_data, wb_en, retired
  );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: 32x32 register file with writeback select, write-through bypass and retire counter
module wb_regfile #(parameter int CNT_W = 32) (
  input logic clk,
  input logic reset,
  wb_regfile_if.slave bus
);
  logic [31:0] regs [32];
  logic [CNT_W-1:0] cnt;
  logic unused_ctrl;
  assign unused_ctrl = ^bus.control[7:2];
  assign bus.wb_data = bus.control[1] ? bus.read_data : bus.alu_result;
  assign bus.wb_en = bus.control[0] & bus.power & ~reset & (bus.write_reg != 5'd0);
  assign bus.retired = cnt;
  // read ports: r0 is hardwired zero, a committing write to the same index is forwarded
  always_comb begin
    bus.rs_data = (bus.rs_addr == 5'd0) ? 32'd0 :
                  (bus.wb_en && bus.rs_addr == bus.write_reg) ? bus.wb_data : regs[bus.rs_addr];
    bus.rt_data = (bus.rt_addr == 5'd0) ? 32'd0 :
                  (bus.wb_en && bus.rt_addr == bus.write_reg) ? bus.wb_data : regs[bus.rt_addr];
  end
  // storage and retire counter: reset clears everything and drops any concurrent write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      cnt <= '0;
    end else if (bus.wb_en) begin
      regs[bus.write_reg] <= bus.wb_data;
      cnt <= cnt + 1'b1;
    end
  end
endmodule
